// File: rtl/rotation_stream_reader_if.sv
// Signal bundle between the rotation stream reader, its coefficient BRAM
// read port, the control side and the downstream rotation stage.
interface rotation_stream_reader_if #(
  parameter int BITMASK_SIZE  = 32,
  parameter int BRAM_MAX_SIZE = 100,
  parameter int DATA_SIZE     = 2
);
  localparam int ADDR_W = $clog2(BRAM_MAX_SIZE);

  // Control side
  logic                    start_in;
  logic [ADDR_W:0]         num_words_in;
  logic [BITMASK_SIZE-1:0] rotation_amount_in;
  logic                    busy_out;
  logic                    done_out;

  // BRAM read port
  logic [ADDR_W-1:0]       bram_addr_out;
  logic [DATA_SIZE-1:0]    bram_data_in;

  // Stream towards the rotation stage
  logic                    valid_data_out;
  logic [ADDR_W-1:0]       addr_out;
  logic [DATA_SIZE-1:0]    data_out;
  logic [BITMASK_SIZE-1:0] rotation_amount_out;

  // The reader is the initiator of the stream.
  modport master (
    input  start_in, num_words_in, rotation_amount_in, bram_data_in,
    output bram_addr_out, valid_data_out, addr_out, data_out,
           rotation_amount_out, busy_out, done_out
  );

  // Environment seen from the other side (control, BRAM, consumer).
  modport slave (
    output start_in, num_words_in, rotation_amount_in, bram_data_in,
    input  bram_addr_out, valid_data_out, addr_out, data_out,
           rotation_amount_out, busy_out, done_out
  );
endinterface

// File: rtl/rotation_stream_reader.sv
// Walks the coefficient BRAM in address order and emits the (addr, data,
// valid) stream for the rotation stage. A tag pipeline as deep as the BRAM
// read latency pairs each returning word with its index; odd rotations get
// one extra wrap word (word 0 re-read) for the half-word splicer downstream.
module rotation_stream_reader #(
  parameter int BITMASK_SIZE  = 32,
  parameter int BRAM_MAX_SIZE = 100,
  parameter int DATA_SIZE     = 2,
  parameter int BRAM_LATENCY  = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  rotation_stream_reader_if.master bus
);
  localparam int ADDR_W = $clog2(BRAM_MAX_SIZE);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(BRAM_MAX_SIZE);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [CNT_W-1:0]        nc_q, nc_d;        // clamped word count of the pass
  logic [CNT_W-1:0]        t_q, t_d;          // words to issue incl. wrap word
  logic [CNT_W-1:0]        cnt_q, cnt_d;      // issues completed before this one
  logic [ADDR_W-1:0]       bram_addr_q, bram_addr_d;
  logic [BITMASK_SIZE-1:0] rot_q, rot_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    valid_q, valid_d;
  logic [DATA_SIZE-1:0]    data_q, data_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [BRAM_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [ADDR_W-1:0]       tag_idx_q [BRAM_LATENCY];
  logic [ADDR_W-1:0]       tag_idx_d [BRAM_LATENCY];

  logic [CNT_W-1:0]        n_clamped;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    issue;

  // Clamp the requested word count to the BRAM depth.
  always_comb begin
    n_clamped = (bus.num_words_in > MAX_WORDS) ? MAX_WORDS : bus.num_words_in;
  end

  // Pass control: accept a start, issue one address per cycle, then drain.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d     = state_q;
    nc_d        = nc_q;
    t_d         = t_q;
    cnt_d       = cnt_q;
    bram_addr_d = bram_addr_q;
    rot_d       = rot_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    issue       = 1'b0;
    cnt_inc     = cnt_q + CNT_ONE;

    case (state_q)
      S_IDLE: begin
        // The done cycle still counts as busy, so a start there is dropped.
        if (bus.start_in && !done_q) begin
          nc_d        = n_clamped;
          rot_d       = bus.rotation_amount_in;
          t_d         = n_clamped + CNT_W'(bus.rotation_amount_in[0]);
          cnt_d       = '0;
          bram_addr_d = '0;
          if (n_clamped == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        issue = 1'b1;
        if (cnt_inc == t_q) begin
          state_d = S_DRAIN;
        end else begin
          cnt_d       = cnt_inc;
          // Past the last real word only the odd-rotation wrap word remains.
          bram_addr_d = (cnt_inc == nc_q) ? '0 : cnt_inc[ADDR_W-1:0];
        end
      end
      S_DRAIN: begin
        // Tags are contiguous, so an empty pipe with a word on the output
        // means the last word is being presented now.
        if ((tag_vld_q == '0) && valid_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Tag pipeline: follows each issued address through the BRAM latency.
  always_comb begin
    tag_vld_d[0] = issue;
    tag_idx_d[0] = bram_addr_q;
    for (int i = 1; i < BRAM_LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_idx_d[i] = tag_idx_q[i-1];
    end
  end

  // Output register: capture BRAM data as its tag leaves the pipe, else hold.
  always_comb begin
    valid_d = tag_vld_q[BRAM_LATENCY-1];
    data_d  = valid_d ? bus.bram_data_in : data_q;
    addr_d  = valid_d ? tag_idx_q[BRAM_LATENCY-1] : addr_q;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= S_IDLE;
      nc_q        <= '0;
      t_q         <= '0;
      cnt_q       <= '0;
      bram_addr_q <= '0;
      rot_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      addr_q      <= '0;
      tag_vld_q   <= '0;
      // NOTE: the tag index array is small flop storage, not a RAM, so it is
      // cleared with the rest; only the valid bits matter for correctness.
      for (int i = 0; i < BRAM_LATENCY; i++) begin
        tag_idx_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      state_q     <= state_d;
      nc_q        <= nc_d;
      t_q         <= t_d;
      cnt_q       <= cnt_d;
      bram_addr_q <= bram_addr_d;
      rot_q       <= rot_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      addr_q      <= addr_d;
      tag_vld_q   <= tag_vld_d;
      tag_idx_q   <= tag_idx_d;
    end
  end

  assign bus.bram_addr_out       = bram_addr_q;
  assign bus.valid_data_out      = valid_q;
  assign bus.addr_out            = addr_q;
  assign bus.data_out            = data_q;
  assign bus.rotation_amount_out = rot_q;
  assign bus.busy_out            = busy_q;
  assign bus.done_out            = done_q;
endmodule

// File: tb/tb_rotation_stream_reader.sv
// Self-checking bench for rotation_stream_reader: a BRAM model with read
// latency, a scoreboard queue of expected stream words, a table of passes
// and hand-written sequences for restart and mid-pass reset.
module tb_rotation_stream_reader;
  localparam int BITMASK_SIZE  = 32;
  localparam int BRAM_MAX_SIZE = 100;
  localparam int DATA_SIZE     = 2;
  localparam int L             = 2;
  localparam int ADDR_W        = $clog2(BRAM_MAX_SIZE);

  typedef struct {
    logic [ADDR_W-1:0]    addr;
    logic [DATA_SIZE-1:0] data;
  } word_t;

  typedef struct {
    logic [ADDR_W:0] n;
    logic [31:0]     rot;
    int              exp_words;
    int              exp_done;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rotation_stream_reader_if #(
    .BITMASK_SIZE(BITMASK_SIZE), .BRAM_MAX_SIZE(BRAM_MAX_SIZE), .DATA_SIZE(DATA_SIZE)
  ) bus_if ();

  rotation_stream_reader #(
    .BITMASK_SIZE(BITMASK_SIZE), .BRAM_MAX_SIZE(BRAM_MAX_SIZE),
    .DATA_SIZE(DATA_SIZE), .BRAM_LATENCY(L)
  ) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus_if)
  );

  // BRAM model: data for the address seen in cycle c appears in cycle c+L.
  logic [DATA_SIZE-1:0] mem     [BRAM_MAX_SIZE];
  logic [DATA_SIZE-1:0] rd_pipe [L];
  always @(posedge clk) begin
    rd_pipe[0] <= (int'(bus_if.bram_addr_out) < BRAM_MAX_SIZE) ? mem[bus_if.bram_addr_out] : '0;
    for (int k = 1; k < L; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign bus_if.bram_data_in = rd_pipe[L-1];

  // Counters and scoreboard, all owned by the single initial block below.
  int    n_checks = 0;
  int    n_fail   = 0;
  word_t sb [$];
  int    words_total = 0, done_total = 0, oob_total = 0, rot_bad_total = 0;
  int    last_done_cyc = -1000, last_busy_cyc = -1000;
  int    run_start_cyc = -1000, last_valid_cyc = -1000;
  int    start_cyc = 0, base_words = 0, base_done = 0, base_oob = 0, base_rot_bad = 0;
  logic  prev_valid = 1'b0;
  logic [31:0]       exp_rot = '0;
  logic [ADDR_W-1:0] addr_log [8192];
  vec_t  vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  // Samples the DUT on the falling edge, away from the active edge.
  task automatic monitor();
    word_t w;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        prev_valid = 1'b0;
      end else begin
        addr_log[cyc & 8191] = bus_if.bram_addr_out;
        if (bus_if.busy_out) begin
          last_busy_cyc = cyc;
          if (int'(bus_if.bram_addr_out) >= BRAM_MAX_SIZE) oob_total++;
          if (bus_if.rotation_amount_out !== exp_rot) rot_bad_total++;
        end
        if (bus_if.valid_data_out) begin
          words_total++;
          if (!prev_valid) run_start_cyc = cyc;
          last_valid_cyc = cyc;
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: got addr %0d data %0d, expected no word",
                     bus_if.addr_out, bus_if.data_out);
          end else begin
            w = sb.pop_front();
            check("word_addr", 64'(bus_if.addr_out), 64'(w.addr));
            check("word_data", 64'(bus_if.data_out), 64'(w.data));
          end
        end
        prev_valid = bus_if.valid_data_out;
        if (bus_if.done_out) begin
          done_total++;
          last_done_cyc = cyc;
          check("busy_low_at_done", 64'(bus_if.busy_out), 64'(0));
        end
      end
    end
  endtask

  // Called at posedge+1; start_in is sampled at the next edge (relative cycle 0).
  task automatic start_pass(input logic [ADDR_W:0] n, input logic [31:0] rot);
    int    nc;
    word_t w;
    start_cyc    = cyc;
    base_words   = words_total;
    base_done    = done_total;
    base_oob     = oob_total;
    base_rot_bad = rot_bad_total;
    exp_rot      = rot;
    nc = (int'(n) > BRAM_MAX_SIZE) ? BRAM_MAX_SIZE : int'(n);
    for (int i = 0; i < nc; i++) begin
      w.addr = ADDR_W'(i);
      w.data = mem[i];
      sb.push_back(w);
    end
    if (nc > 0 && rot[0]) begin
      w.addr = '0;
      w.data = mem[0];
      sb.push_back(w);
    end
    bus_if.start_in           = 1'b1;
    bus_if.num_words_in       = n;
    bus_if.rotation_amount_in = rot;
    @(posedge clk); #1;
    bus_if.start_in = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (done_total == base_done && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    if (done_total == base_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done_out in %0d cycles, expected one", k);
    end
  endtask

  task automatic check_pass(input logic [31:0] rot, input int exp_words, input int exp_done);
    check("word_count", 64'(words_total - base_words), 64'(exp_words));
    check("sb_drained", 64'(sb.size()), 64'(0));
    check("done_pulses", 64'(done_total - base_done), 64'(1));
    check("done_cycle", 64'(last_done_cyc - start_cyc), 64'(exp_done));
    check("busy_seen", 64'(last_busy_cyc > start_cyc), 64'(exp_words > 0));
    check("rot_out", 64'(bus_if.rotation_amount_out), 64'(rot));
    check("rot_stable", 64'(rot_bad_total - base_rot_bad), 64'(0));
    check("addr_in_range", 64'(oob_total - base_oob), 64'(0));
    if (exp_words > 0) begin
      check("first_valid_cycle", 64'(run_start_cyc - start_cyc), 64'(L + 2));
      check("last_valid_cycle", 64'(last_valid_cyc - start_cyc), 64'(exp_done - 1));
    end
  endtask

  task automatic run_pass(input logic [ADDR_W:0] n, input logic [31:0] rot,
                          input int exp_words, input int exp_done);
    @(posedge clk); #1;
    start_pass(n, rot);
    wait_done();
    repeat (2) @(posedge clk);
    #1;
    check_pass(rot, exp_words, exp_done);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"},     64'(bus_if.valid_data_out), 64'(0));
    check({tag, "_busy"},      64'(bus_if.busy_out), 64'(0));
    check({tag, "_done"},      64'(bus_if.done_out), 64'(0));
    check({tag, "_addr"},      64'(bus_if.addr_out), 64'(0));
    check({tag, "_data"},      64'(bus_if.data_out), 64'(0));
    check({tag, "_bram_addr"}, 64'(bus_if.bram_addr_out), 64'(0));
    check({tag, "_rot"},       64'(bus_if.rotation_amount_out), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int snap_words, snap_done;

    // Expected word count and done cycle derive from T = min(N,100) + rot[0]:
    // done lands T + L + 2 cycles after the start edge, or 1 when N is 0.
    vecs[0] = '{n: 8'd4,   rot: 32'd3,          exp_words: 5,   exp_done: 9};
    vecs[1] = '{n: 8'd0,   rot: 32'd6,          exp_words: 0,   exp_done: 1};
    vecs[2] = '{n: 8'd150, rot: 32'd2,          exp_words: 100, exp_done: 104};
    vecs[3] = '{n: 8'd100, rot: 32'd1,          exp_words: 101, exp_done: 105};
    vecs[4] = '{n: 8'd1,   rot: 32'd1,          exp_words: 2,   exp_done: 6};
    vecs[5] = '{n: 8'd1,   rot: 32'd0,          exp_words: 1,   exp_done: 5};
    vecs[6] = '{n: 8'd0,   rot: 32'd1,          exp_words: 0,   exp_done: 1};
    vecs[7] = '{n: 8'd7,   rot: 32'hFFFF_FFFF,  exp_words: 8,   exp_done: 12};

    for (int i = 0; i < BRAM_MAX_SIZE; i++) mem[i] = DATA_SIZE'(i % 4);
    for (int i = 0; i < L; i++) rd_pipe[i] = '0;

    rst_n                     = 1'b0;
    bus_if.start_in           = 1'b0;
    bus_if.num_words_in       = '0;
    bus_if.rotation_amount_in = '0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;

    // Rotation 4, N=5: addresses 0..4 in cycles 1..5, words in cycles 4..8
    run_pass(8'd5, 32'd4, 5, 9);
    for (int j = 1; j <= 5; j++)
      check("issue_addr", 64'(addr_log[(start_cyc + j) & 8191]), 64'(j - 1));

    // Table of passes
    for (int i = 0; i < 8; i++)
      run_pass(vecs[i].n, vecs[i].rot, vecs[i].exp_words, vecs[i].exp_done);

    // Start pulsed mid-pass and in the done cycle is ignored; start in the
    // cycle after done is accepted with its new rotation.
    @(posedge clk); #1;
    start_pass(8'd10, 32'd2);
    k = 0;
    while (!bus_if.done_out && k < 200) begin
      k++;
      if ((cyc - start_cyc) == 3 || (cyc - start_cyc) == 4) begin
        bus_if.start_in           = 1'b1;
        bus_if.num_words_in       = 8'd20;
        bus_if.rotation_amount_in = 32'd5;
      end else begin
        bus_if.start_in = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus_if.start_in           = 1'b1;
    bus_if.num_words_in       = 8'd20;
    bus_if.rotation_amount_in = 32'd5;
    @(posedge clk); #1;
    bus_if.start_in = 1'b0;
    check_pass(32'd2, 10, 14);
    start_pass(8'd3, 32'd7);
    wait_done();
    repeat (2) @(posedge clk);
    #1;
    check_pass(32'd7, 4, 8);

    // Reset at word 2 of a 10-word pass aborts it; next pass is clean.
    @(posedge clk); #1;
    start_pass(8'd10, 32'd0);
    k = 0;
    while (!(bus_if.valid_data_out && bus_if.addr_out == 2) && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("reached_word2", 64'(bus_if.addr_out), 64'(2));
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    @(posedge clk); #1;
    rst_n      = 1'b1;
    snap_words = words_total;
    snap_done  = done_total;
    repeat (20) @(posedge clk);
    #1;
    check("no_words_after_abort", 64'(words_total - snap_words), 64'(0));
    check("no_done_after_abort", 64'(done_total - snap_done), 64'(0));
    run_pass(8'd10, 32'd0, 10, 14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
